franken_lsu: RTL and testbench
==============================

Name: franken_lsu

Overview:
Parametrised load/store unit for the Frankenstein multicycle core. It replaces the ad-hoc byte-lane logic of the single-cycle datapath with a handshaked unit between the core's memory stage and a single-port data memory. It supports all RV32I load/store sizes (b/h/w, signed/unsigned). Misaligned accesses are either split into two aligned bus beats or rejected with an error, selected by parameter.

Parameters:
ADDR_W, 32, byte-address width; memory side is word-addressed by ADDR_W-2 upper bits
MISALIGN_SPLIT, 1, 1 = split word-crossing accesses into two beats; 0 = reject them with rsp_err

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high; returns the block to IDLE immediately
req_valid  in  1  core request valid
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load result (lbu/lhu); ignored for stores and for word size
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse; no backpressure
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid: misaligned (when MISALIGN_SPLIT=0) or illegal size
mem_valid  out  1  bus beat valid
mem_ready  in  1  bus accepts beat when mem_valid & mem_ready
mem_we  out  1  beat is a write
mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 00
mem_be  out  4  byte enables
mem_wdata  out  32  lane-shifted write data
mem_rvalid  in  1  read data valid; earliest one cycle after read beat acceptance
mem_rdata  in  32  read word

Behaviour:
- Reset values: req_ready=1 after reset release. mem_valid, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_rdata and rsp_err are all 0. Every output is registered.
- FSM states: IDLE, BEAT1, WAIT1, BEAT2, WAIT2, RESP.
- IDLE: on req_valid & req_ready, latch the request and decode it:
  - offset = addr[1:0]; mask = 0001 (b) / 0011 (h) / 1111 (w).
  - The access crosses a word when offset + bytes > 4.
  - Illegal size, or a crossing access with MISALIGN_SPLIT=0, goes to RESP with err=1, with no bus activity.
  - Otherwise go to BEAT1.
- BEAT1:
  - mem_addr = {addr[ADDR_W-1:2],00}; mem_be = (mask<<offset)[3:0]; mem_wdata = wdata<<(8*offset).
  - Hold all bus outputs stable until mem_ready.
  - On acceptance:
    - Read: go to WAIT1.
    - Write: go to BEAT2 if crossing, else RESP.
- WAIT1: on mem_rvalid, capture rdata>>(8*offset) into the low assembly bytes. Then go to BEAT2 if crossing, else RESP.
- BEAT2:
  - mem_addr = previous word address + 4, wrapping modulo 2^ADDR_W.
  - mem_be = mask>>(4-offset); mem_wdata = wdata>>(8*(4-offset)).
  - Handshake rules as in BEAT1; a read goes to WAIT2, a write goes to RESP.
- WAIT2: on mem_rvalid, OR rdata<<(8*(4-offset)) into the assembly. Go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata is the assembled value truncated to the access size, then extended:
  - sign-extended when req_unsigned=0;
  - zero-extended when req_unsigned=1.
- Latency:
  - Aligned load with mem_ready=1 and rvalid one cycle later: accept at edge 0, mem_valid in cycle 1, rvalid in cycle 2, rsp_valid in cycle 3.
  - Aligned store: rsp_valid 2 cycles after accept.
  - Error: rsp_valid in the cycle after accept.
- Only one transaction is outstanding. req_ready=0 outside IDLE. Requests presented while busy are not accepted.
- mem_rvalid outside WAIT1/WAIT2 is ignored.
- Reset mid-operation: all outputs return to reset values asynchronously. No rsp_valid is produced for the aborted request. A late rvalid after reset is ignored.
- mem_be never has bits set outside the access. mem_wdata lanes outside mem_be are 0.

Decomposition:
- franken_lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W;
  - the lsu_state_t enum;
  - the mask lookup function.
- One combinational sub-module, franken_lsu_align. It takes offset, size, beat number, wdata and the two read words, and produces be, shifted wdata and the extended load result. This keeps the FSM file limited to control.

Test Plan:
1. lbu 0x101 with word@0x100=0x12345678 → one beat, be=0010, rsp_rdata=0x00000056. lb 0x103 with word=0x9A345678 → 0xFFFFFF9A.
2. sw 0x102, wdata 0xAABBCCDD, split=1 → beat1 addr 0x100, be 1100, wdata 0xCCDD0000; beat2 addr 0x104, be 0011, wdata 0x0000AABB; then one rsp_valid with err=0.
3. lh 0x203 signed, word@0x200=0x80112233, word@0x204=0x445566F7 → be 1000 then 0001; rsp_rdata=0xFFFFF780. With lhu → 0x0000F780.
4. lw 0xFFFFFFFE → beats at 0xFFFFFFFC (be 1100) and 0x00000000 (be 0011), assembled from the upper half of the first word and the lower half of the second.
5. MISALIGN_SPLIT=0, lw 0x101 → mem_valid never asserted, rsp_valid in the cycle after accept, rsp_err=1, rsp_rdata=0. Also size=11 → rsp_err=1.
6. Hold mem_ready=0 for 5 cycles in BEAT1 → bus outputs stable throughout. Then assert reset during WAIT1 → mem_valid=0 immediately, req_ready=1 after release, a stray rvalid produces no rsp_valid.

Source files
------------

// File: rtl/franken_lsu_pkg.sv
// Shared encodings, FSM state type and size helpers for the load/store unit.
package franken_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT1 = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_BEAT2 = 3'd3,
    ST_WAIT2 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_t;

  // Right-aligned byte mask for an access size; illegal size yields 0.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // True when the access spills past the end of its word.
  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
    logic [2:0] nbytes;
    case (size)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      SZ_W:    nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    return ({1'b0, off} + nbytes) > 3'd4;
  endfunction

endpackage

// File: rtl/franken_lsu_align.sv
// Byte-lane steering: byte enables and shifted store data for the current
// beat, plus assembly and extension of the load result from both read words.
module franken_lsu_align
  import franken_lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        beat2_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rd0_i,
  input  logic [31:0] rd1_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  be_wide;
  logic [31:0] wmasked;
  logic [63:0] w_wide;
  logic [63:0] r_wide;
  logic [31:0] r_asm;

  // Two-word windows: beat 1 takes the low half, beat 2 the spill-over.
  always_comb begin
    be_wide = {4'b0000, size_mask(size_i)} << off_i;
    be_o    = beat2_i ? be_wide[7:4] : be_wide[3:0];

    case (size_i)
      SZ_B:    wmasked = {24'h0, wdata_i[7:0]};
      SZ_H:    wmasked = {16'h0, wdata_i[15:0]};
      default: wmasked = wdata_i;
    endcase
    w_wide  = {32'h0, wmasked} << {off_i, 3'b000};
    wdata_o = beat2_i ? w_wide[63:32] : w_wide[31:0];

    r_wide = {rd1_i, rd0_i} >> {off_i, 3'b000};
    r_asm  = r_wide[31:0];
    case (size_i)
      SZ_B:    rdata_o = unsigned_i ? {24'h0, r_asm[7:0]}  : {{24{r_asm[7]}}, r_asm[7:0]};
      SZ_H:    rdata_o = unsigned_i ? {16'h0, r_asm[15:0]} : {{16{r_asm[15]}}, r_asm[15:0]};
      default: rdata_o = r_asm;
    endcase
  end

endmodule

// File: rtl/franken_lsu.sv
// Handshaked load/store unit between the core memory stage and a single-port
// word-addressed data memory. One transaction in flight; misaligned
// word-crossing accesses are split into two beats or rejected.
//
// Handshake: a request transfers on a rising edge with req_valid_i & req_ready_o;
// a bus beat transfers with mem_valid_o & mem_ready_i and its outputs are held
// until then; mem_rvalid_i and rsp_valid_o are single-cycle pulses with no
// backpressure.
module franken_lsu
  import franken_lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd0_q, rd0_d;
  logic [31:0]       rd1_q, rd1_d;
  logic              err_q, err_d;
  logic              req_cross;

  logic              req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic              mem_valid_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;

  logic              beat_d, beat2_d;
  logic [ADDR_W-1:0] word_addr_d;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_rdata;

  assign req_cross = crosses_word(size_q, addr_q[1:0]);

  // Next-state, request latching and read-word capture.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rd0_d   = 32'h0;
          rd1_d   = 32'h0;
          if ((size_mask(req_size_i) == 4'b0000) ||
              (crosses_word(req_size_i, req_addr_i[1:0]) && !MISALIGN_SPLIT)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_BEAT1;
          end
        end
      end
      ST_BEAT1: begin
        if (mem_ready_i) begin
          if (!we_q)          state_d = ST_WAIT1;
          else if (req_cross) state_d = ST_BEAT2;
          else                state_d = ST_RESP;
        end
      end
      ST_WAIT1: begin
        if (mem_rvalid_i) begin
          rd0_d   = mem_rdata_i;
          state_d = req_cross ? ST_BEAT2 : ST_RESP;
        end
      end
      ST_BEAT2: begin
        if (mem_ready_i) state_d = we_q ? ST_RESP : ST_WAIT2;
      end
      ST_WAIT2: begin
        if (mem_rvalid_i) begin
          rd1_d   = mem_rdata_i;
          state_d = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign beat_d      = (state_d == ST_BEAT1) || (state_d == ST_BEAT2);
  assign beat2_d     = (state_d == ST_BEAT2);
  assign word_addr_d = {addr_d[ADDR_W-1:2], 2'b00};

  franken_lsu_align u_align (
    .off_i      (addr_d[1:0]),
    .size_i     (size_d),
    .beat2_i    (beat2_d),
    .unsigned_i (uns_d),
    .wdata_i    (wdata_d),
    .rd0_i      (rd0_d),
    .rd1_i      (rd1_d),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  // State and latched request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rd0_q   <= 32'h0;
      rd1_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      err_q   <= err_d;
    end
  end

  // Registered outputs, computed from the state being entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      rsp_err_q   <= (state_d == ST_RESP) && err_d;
      rsp_rdata_q <= ((state_d == ST_RESP) && !err_d && !we_d) ? al_rdata : 32'h0;
      mem_valid_q <= beat_d;
      mem_we_q    <= beat_d && we_d;
      mem_addr_q  <= !beat_d ? '0 : (beat2_d ? word_addr_d + ADDR_W'(4) : word_addr_d);
      mem_be_q    <= beat_d ? al_be : 4'b0000;
      mem_wdata_q <= (beat_d && we_d) ? al_wdata : 32'h0;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_franken_lsu.sv
// Bench for franken_lsu: a vector table run through a split-mode instance
// with a small bus responder, plus hand sequences for stall/reset and the
// reject-mode instance.
module tb_franken_lsu;
  import franken_lsu_pkg::*;

  localparam logic [1:0] SZ_ILL = 2'b11;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus
  logic        req_valid_s = 1'b0, req_valid_r = 1'b0;
  logic        req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        mem_ready = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  // split-mode outputs
  logic        req_ready_s, rsp_valid_s, rsp_err_s, mem_valid_s, mem_we_s;
  logic [31:0] rsp_rdata_s, mem_addr_s, mem_wdata_s;
  logic [3:0]  mem_be_s;
  // reject-mode outputs
  logic        req_ready_r, rsp_valid_r, rsp_err_r, mem_valid_r, mem_we_r;
  logic [31:0] rsp_rdata_r, mem_addr_r, mem_wdata_r;
  logic [3:0]  mem_be_r;

  franken_lsu #(.ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dut_s (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_s), .req_ready_o(req_ready_s),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid_s),
    .rsp_rdata_o(rsp_rdata_s), .rsp_err_o(rsp_err_s), .mem_valid_o(mem_valid_s),
    .mem_ready_i(mem_ready), .mem_we_o(mem_we_s), .mem_addr_o(mem_addr_s),
    .mem_be_o(mem_be_s), .mem_wdata_o(mem_wdata_s), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata)
  );

  franken_lsu #(.ADDR_W(32), .MISALIGN_SPLIT(1'b0)) dut_r (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_r), .req_ready_o(req_ready_r),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid_r),
    .rsp_rdata_o(rsp_rdata_r), .rsp_err_o(rsp_err_r), .mem_valid_o(mem_valid_r),
    .mem_ready_i(mem_ready), .mem_we_o(mem_we_r), .mem_addr_o(mem_addr_r),
    .mem_be_o(mem_be_r), .mem_wdata_o(mem_wdata_r), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata)
  );

  // bus responder: returns read data one cycle after each accepted read beat
  logic        resp_en = 1'b1;
  logic        force_rvalid = 1'b0;
  logic [31:0] cur_word0 = 32'h0, cur_m0 = 32'h0, cur_m1 = 32'h0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_word = 32'h0;

  always @(negedge clk) begin
    if (force_rvalid) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBADC0DE5;
    end else if (rd_pend) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd_word;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    rd_pend = 1'b0;
    if (resp_en && mem_valid_s && mem_ready && !mem_we_s) begin
      rd_pend = 1'b1;
      rd_word = (mem_addr_s == cur_word0) ? cur_m0 : cur_m1;
    end
  end

  // vector table
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          nb;
    logic [3:0]  be1;
    logic [3:0]  be2;
    logic [31:0] wd1;
    logic [31:0] wd2;
    int          lat;
  } vec_t;

  vec_t vt[16];

  // scoreboard
  logic [68:0] exp_beat_q[$];
  logic [32:0] exp_rsp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [68:0] got, input logic [68:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [68:0] got;
    logic [31:0] w0;
    bit          done;
    int          lat;
    w0        = {v.addr[31:2], 2'b00};
    cur_word0 = w0;
    cur_m0    = v.m0;
    cur_m1    = v.m1;
    if (v.nb >= 1) exp_beat_q.push_back({v.we, w0, v.be1, v.we ? v.wd1 : 32'h0});
    if (v.nb == 2) exp_beat_q.push_back({v.we, w0 + 32'd4, v.be2, v.we ? v.wd2 : 32'h0});
    exp_rsp_q.push_back({v.exp_err, v.exp_rdata});
    for (int i = 0; i < 20 && !req_ready_s; i++) begin
      @(posedge clk); #1;
    end
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid_s  = 1'b1;
    @(posedge clk); #1;
    req_valid_s  = 1'b0;
    done = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 60 && !done; i++) begin
      @(negedge clk);
      if (mem_valid_s && mem_ready) begin
        got = {mem_we_s, mem_addr_s, mem_be_s, mem_we_s ? mem_wdata_s : 32'h0};
        if (exp_beat_q.size() == 0) fail_now({nm, " unexpected beat"});
        else chk({nm, " beat"}, got, exp_beat_q.pop_front());
      end
      if (rsp_valid_s) begin
        done = 1'b1;
        lat  = i;
        chk({nm, " rsp"}, {36'h0, rsp_err_s, rsp_rdata_s}, {36'h0, exp_rsp_q.pop_front()});
      end
    end
    if (!done) begin
      fail_now({nm, " rsp timeout"});
      exp_rsp_q.delete();
    end
    chk({nm, " latency"}, 69'(lat), 69'(v.lat));
    if (exp_beat_q.size() != 0) begin
      fail_now({nm, " missing beats"});
      exp_beat_q.delete();
    end
    @(negedge clk);
    chk({nm, " single pulse"}, {68'h0, rsp_valid_s}, 69'h0);
    @(posedge clk); #1;
  endtask

  // request to the reject-mode unit that must error without bus activity
  task automatic run_rej(input logic [31:0] addr, input logic [1:0] size, input string nm);
    bit saw_bus;
    int lat, nrsp;
    logic [32:0] got;
    req_we      = 1'b0;
    req_size    = size;
    req_addr    = addr;
    req_valid_r = 1'b1;
    @(posedge clk); #1;
    req_valid_r = 1'b0;
    saw_bus = 1'b0; lat = 0; nrsp = 0; got = 33'h0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_valid_r) saw_bus = 1'b1;
      if (rsp_valid_r) begin
        nrsp++;
        if (lat == 0) begin
          lat = i;
          got = {rsp_err_r, rsp_rdata_r};
        end
      end
    end
    chk({nm, " latency"}, 69'(lat), 69'd1);
    chk({nm, " rsp"}, {36'h0, got}, {36'h0, 1'b1, 32'h0});
    chk({nm, " no bus"}, {68'h0, saw_bus}, 69'h0);
    chk({nm, " one rsp"}, 69'(nrsp), 69'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    bit stray;
    // we, size, uns, addr, wdata, m0, m1, rdata, err, nb, be1, be2, wd1, wd2, lat
    vt[0]  = '{1'b0, SZ_B,   1'b1, 32'h00000101, 32'h0,        32'h12345678, 32'h0,        32'h00000056, 1'b0, 1, 4'b0010, 4'b0000, 32'h0,        32'h0,        3};
    vt[1]  = '{1'b0, SZ_B,   1'b0, 32'h00000103, 32'h0,        32'h9A345678, 32'h0,        32'hFFFFFF9A, 1'b0, 1, 4'b1000, 4'b0000, 32'h0,        32'h0,        3};
    vt[2]  = '{1'b1, SZ_W,   1'b0, 32'h00000102, 32'hAABBCCDD, 32'h0,        32'h0,        32'h0,        1'b0, 2, 4'b1100, 4'b0011, 32'hCCDD0000, 32'h0000AABB, 3};
    vt[3]  = '{1'b0, SZ_H,   1'b0, 32'h00000203, 32'h0,        32'h80112233, 32'h445566F7, 32'hFFFFF780, 1'b0, 2, 4'b1000, 4'b0001, 32'h0,        32'h0,        5};
    vt[4]  = '{1'b0, SZ_H,   1'b1, 32'h00000203, 32'h0,        32'h80112233, 32'h445566F7, 32'h0000F780, 1'b0, 2, 4'b1000, 4'b0001, 32'h0,        32'h0,        5};
    vt[5]  = '{1'b0, SZ_W,   1'b1, 32'hFFFFFFFE, 32'h0,        32'h11223344, 32'h55667788, 32'h77881122, 1'b0, 2, 4'b1100, 4'b0011, 32'h0,        32'h0,        5};
    vt[6]  = '{1'b1, SZ_B,   1'b0, 32'h00000003, 32'h123456EF, 32'h0,        32'h0,        32'h0,        1'b0, 1, 4'b1000, 4'b0000, 32'hEF000000, 32'h0,        2};
    vt[7]  = '{1'b1, SZ_H,   1'b0, 32'h00000002, 32'hFFFFBEEF, 32'h0,        32'h0,        32'h0,        1'b0, 1, 4'b1100, 4'b0000, 32'hBEEF0000, 32'h0,        2};
    vt[8]  = '{1'b0, SZ_W,   1'b1, 32'h00000300, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 1, 4'b1111, 4'b0000, 32'h0,        32'h0,        3};
    vt[9]  = '{1'b0, SZ_H,   1'b0, 32'h00000302, 32'h0,        32'h7FFF0000, 32'h0,        32'h00007FFF, 1'b0, 1, 4'b1100, 4'b0000, 32'h0,        32'h0,        3};
    vt[10] = '{1'b0, SZ_H,   1'b1, 32'h00000301, 32'h0,        32'h00ABCD00, 32'h0,        32'h0000ABCD, 1'b0, 1, 4'b0110, 4'b0000, 32'h0,        32'h0,        3};
    vt[11] = '{1'b0, SZ_ILL, 1'b0, 32'h00000100, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 0, 4'b0000, 4'b0000, 32'h0,        32'h0,        1};
    vt[12] = '{1'b1, SZ_W,   1'b0, 32'h00000107, 32'h11223344, 32'h0,        32'h0,        32'h0,        1'b0, 2, 4'b1000, 4'b0111, 32'h44000000, 32'h00112233, 3};
    vt[13] = '{1'b0, SZ_B,   1'b0, 32'h00000002, 32'h0,        32'h00800000, 32'h0,        32'hFFFFFF80, 1'b0, 1, 4'b0100, 4'b0000, 32'h0,        32'h0,        3};
    vt[14] = '{1'b1, SZ_H,   1'b0, 32'h00000003, 32'h0000CAFE, 32'h0,        32'h0,        32'h0,        1'b0, 2, 4'b1000, 4'b0001, 32'hFE000000, 32'h000000CA, 3};
    vt[15] = '{1'b1, SZ_ILL, 1'b0, 32'h00000200, 32'h12345678, 32'h0,        32'h0,        32'h0,        1'b1, 0, 4'b0000, 4'b0000, 32'h0,        32'h0,        1};

    // reset values after release
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset split", {req_ready_s, rsp_valid_s, rsp_err_s, rsp_rdata_s, mem_valid_s, mem_we_s, mem_be_s, mem_addr_s[27:0]},
        {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 28'h0});
    chk("reset split addr/wdata", {5'h0, mem_addr_s, mem_wdata_s}, 69'h0);
    chk("reset reject", {req_ready_r, rsp_valid_r, rsp_err_r, rsp_rdata_r, mem_valid_r, mem_we_r, mem_be_r, mem_addr_r[27:0]},
        {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 28'h0});
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // stall in BEAT1 for five cycles, then reset while waiting for read data
    resp_en      = 1'b0;
    mem_ready    = 1'b0;
    req_we       = 1'b0;
    req_size     = SZ_W;
    req_unsigned = 1'b0;
    req_addr     = 32'h00000100;
    req_valid_s  = 1'b1;
    @(posedge clk); #1;
    req_valid_s  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall c%0d", i), {31'h0, mem_valid_s, req_ready_s, mem_we_s, mem_addr_s, mem_be_s},
          {31'h0, 1'b1, 1'b0, 1'b0, 32'h00000100, 4'b1111});
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait1 bus idle", {67'h0, mem_valid_s, req_ready_s}, 69'h0);
    rst = 1'b1;
    #1;
    chk("async reset", {67'h0, mem_valid_s, rsp_valid_s}, 69'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    force_rvalid = 1'b1;
    @(negedge clk);
    chk("ready after reset", {68'h0, req_ready_s}, 69'h1);
    @(posedge clk); #1;
    force_rvalid = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid_s || mem_valid_s) stray = 1'b1;
    end
    chk("no rsp after abort", {68'h0, stray}, 69'h0);
    resp_en = 1'b1;
    @(posedge clk); #1;
    run_vec(vt[8], "post-reset");
    run_vec(vt[5], "post-reset wrap");

    // reject-mode instance
    run_rej(32'h00000101, SZ_W, "rej lw");
    run_rej(32'h00000203, SZ_H, "rej lh");
    run_rej(32'h00000100, SZ_ILL, "rej size");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // absolute guard against a stuck run
  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
